// File: rtl/axi4_burst_monitor.sv
// axi4_burst_monitor: passive AXI4 burst-tracking checker.
// Records each burst length from AW/AR, follows the W/R beats against that
// length, matches write bursts to B responses, and keeps sticky violation flags
// plus saturating counts of completed bursts. It drives nothing onto the bus.
//
// Handshake semantics: a transfer on any channel happens exactly when its
// valid and ready are both high at a rising clock edge. A valid that was high
// without ready must stay high until the transfer. Dropping it early is a
// protocol violation and is flagged.

// Per-direction burst tracker. It holds the queue of outstanding burst lengths
// and the beat counter of the burst at the head of that queue.
module axi4_burst_monitor_trk #(
  parameter int MAX_OUT = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,      // address handshake
  input  logic [7:0] i_len,       // burst length - 1
  input  logic       i_beat,      // data handshake
  input  logic       i_last,      // last flag carried by the data beat
  output logic       o_done,      // beat completed the head burst
  output logic       o_last_err,  // last flag disagrees with the counted length
  output logic       o_ovf_err,   // push to a full queue, dropped
  output logic       o_empty_err  // data beat with no outstanding burst
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL = OW'(MAX_OUT);

  logic [7:0]    r_mem [MAX_OUT];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [OW-1:0] r_cnt;
  logic [7:0]    r_beat;

  logic       w_empty;
  logic       w_full;
  logic       w_valid_beat;
  logic       w_exp_last;
  logic       w_push_ok;
  logic [7:0] w_head;

  // Decode the beat against the head length. A pop in the same cycle makes room
  // for a push, even when the queue is full.
  always_comb begin
    w_empty      = (r_cnt == '0);
    w_full       = (r_cnt == FULL);
    w_head       = r_mem[r_rd];
    w_valid_beat = i_beat && !w_empty;
    w_exp_last   = (r_beat == w_head);
    o_done       = w_valid_beat && w_exp_last;
    o_last_err   = w_valid_beat && (i_last != w_exp_last);
    o_empty_err  = i_beat && w_empty;
    w_push_ok    = i_push && (!w_full || o_done);
    o_ovf_err    = i_push && !w_push_ok;
  end

  // Length storage. Only the entries between the pointers are meaningful, so
  // this storage has no reset.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_len;
  end

  // Queue pointers, occupancy and the beat counter. The counter follows the
  // recorded length, not the last flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_beat <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + PW'(1);
      if (o_done)    r_rd <= r_rd + PW'(1);
      case ({w_push_ok, o_done})
        2'b10:   r_cnt <= r_cnt + OW'(1);
        2'b01:   r_cnt <= r_cnt - OW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_valid_beat) r_beat <= w_exp_last ? 8'd0 : r_beat + 8'd1;
    end
  end

endmodule

module axi4_burst_monitor #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_awvalid,
  input  logic             i_awready,
  input  logic [7:0]       i_awlen,
  input  logic             i_wvalid,
  input  logic             i_wready,
  input  logic             i_wlast,
  input  logic             i_bvalid,
  input  logic             i_bready,
  input  logic             i_arvalid,
  input  logic             i_arready,
  input  logic [7:0]       i_arlen,
  input  logic             i_rvalid,
  input  logic             i_rready,
  input  logic             i_rlast,
  output logic [7:0]       o_status,
  output logic             o_asserted,
  output logic [CNT_W-1:0] o_wr_bursts,
  output logic [CNT_W-1:0] o_rd_bursts
);

  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam logic [OW-1:0] FULL = OW'(MAX_OUT);

  logic [7:0]       r_status;
  logic             r_asserted;
  logic [CNT_W-1:0] r_wr_bursts;
  logic [CNT_W-1:0] r_rd_bursts;
  logic [OW-1:0]    r_pend_b;
  logic [4:0]       r_wait;   // {b, r, ar, w, aw}: valid was high without ready

  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_b_hs;
  logic       w_ar_hs;
  logic       w_r_hs;
  logic       w_w_done;
  logic       w_w_last_err;
  logic       w_aw_ovf;
  logic       w_w_empty;
  logic       w_r_done;
  logic       w_r_last_err;
  logic       w_ar_ovf;
  logic       w_r_empty;
  logic       w_b_ok;
  logic       w_b_err;
  logic       w_pend_inc;
  logic       w_pend_ovf;
  logic [4:0] w_wait;
  logic [4:0] w_valid;
  logic [7:0] w_status_set;

  assign w_aw_hs = i_awvalid && i_awready;
  assign w_w_hs  = i_wvalid  && i_wready;
  assign w_b_hs  = i_bvalid  && i_bready;
  assign w_ar_hs = i_arvalid && i_arready;
  assign w_r_hs  = i_rvalid  && i_rready;

  axi4_burst_monitor_trk #(.MAX_OUT(MAX_OUT)) u_wr_trk (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_aw_hs),
    .i_len       (i_awlen),
    .i_beat      (w_w_hs),
    .i_last      (i_wlast),
    .o_done      (w_w_done),
    .o_last_err  (w_w_last_err),
    .o_ovf_err   (w_aw_ovf),
    .o_empty_err (w_w_empty)
  );

  axi4_burst_monitor_trk #(.MAX_OUT(MAX_OUT)) u_rd_trk (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_ar_hs),
    .i_len       (i_arlen),
    .i_beat      (w_r_hs),
    .i_last      (i_rlast),
    .o_done      (w_r_done),
    .o_last_err  (w_r_last_err),
    .o_ovf_err   (w_ar_ovf),
    .o_empty_err (w_r_empty)
  );

  // Collect violations. A B with nothing pending is not counted. A completed
  // write burst that would take pending-B past MAX_OUT is flagged, unless a
  // B retires in the same cycle.
  always_comb begin
    w_valid      = {i_bvalid, i_rvalid, i_arvalid, i_wvalid, i_awvalid};
    w_wait       = w_valid & ~{i_bready, i_rready, i_arready, i_wready, i_awready};
    w_b_ok       = w_b_hs && (r_pend_b != '0);
    w_b_err      = w_b_hs && (r_pend_b == '0);
    w_pend_ovf   = w_w_done && !w_b_ok && (r_pend_b == FULL);
    w_pend_inc   = w_w_done && !w_pend_ovf;
    w_status_set = {(w_aw_ovf | w_ar_ovf | w_w_empty | w_r_empty | w_b_err | w_pend_ovf),
                    w_r_last_err, w_w_last_err, (r_wait & ~w_valid)};
  end

  // Sticky flags, registered summary, pending-B tracking and saturating counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_status    <= '0;
      r_asserted  <= 1'b0;
      r_wr_bursts <= '0;
      r_rd_bursts <= '0;
      r_pend_b    <= '0;
      r_wait      <= '0;
    end else begin
      r_status   <= r_status | w_status_set;
      r_asserted <= |r_status;
      r_wait     <= w_wait;
      case ({w_pend_inc, w_b_ok})
        2'b10:   r_pend_b <= r_pend_b + OW'(1);
        2'b01:   r_pend_b <= r_pend_b - OW'(1);
        default: r_pend_b <= r_pend_b;
      endcase
      if (w_b_ok && (r_wr_bursts != '1))   r_wr_bursts <= r_wr_bursts + CNT_W'(1);
      if (w_r_done && (r_rd_bursts != '1)) r_rd_bursts <= r_rd_bursts + CNT_W'(1);
    end
  end

  assign o_status    = r_status;
  assign o_asserted  = r_asserted;
  assign o_wr_bursts = r_wr_bursts;
  assign o_rd_bursts = r_rd_bursts;

endmodule

// File: tb/tb_axi4_burst_monitor.sv
// Directed testbench for axi4_burst_monitor (MAX_OUT=4, CNT_W=16).
module tb_axi4_burst_monitor;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_awvalid, i_awready, i_wvalid, i_wready, i_wlast, i_bvalid, i_bready;
  logic        i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [7:0]  i_awlen, i_arlen;
  logic [7:0]  o_status;
  logic        o_asserted;
  logic [15:0] o_wr_bursts, o_rd_bursts;

  int n_checks = 0;
  int n_errors = 0;

  axi4_burst_monitor #(.MAX_OUT(4), .CNT_W(16)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_awvalid   (i_awvalid),
    .i_awready   (i_awready),
    .i_awlen     (i_awlen),
    .i_wvalid    (i_wvalid),
    .i_wready    (i_wready),
    .i_wlast     (i_wlast),
    .i_bvalid    (i_bvalid),
    .i_bready    (i_bready),
    .i_arvalid   (i_arvalid),
    .i_arready   (i_arready),
    .i_arlen     (i_arlen),
    .i_rvalid    (i_rvalid),
    .i_rready    (i_rready),
    .i_rlast     (i_rlast),
    .o_status    (o_status),
    .o_asserted  (o_asserted),
    .o_wr_bursts (o_wr_bursts),
    .o_rd_bursts (o_rd_bursts)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_awvalid = 0; i_awready = 1; i_awlen = 0;
    i_wvalid  = 0; i_wready  = 1; i_wlast = 0;
    i_bvalid  = 0; i_bready  = 1;
    i_arvalid = 0; i_arready = 1; i_arlen = 0;
    i_rvalid  = 0; i_rready  = 1; i_rlast = 0;
  endtask

  task automatic apply_reset();
    idle();
    i_reset = 1;
    tick();
    tick();
    i_reset = 0;
  endtask

  task automatic do_aw(input logic [7:0] len);
    i_awvalid = 1; i_awlen = len; tick(); i_awvalid = 0;
  endtask

  task automatic do_w(input logic last);
    i_wvalid = 1; i_wlast = last; tick(); i_wvalid = 0; i_wlast = 0;
  endtask

  task automatic do_b();
    i_bvalid = 1; tick(); i_bvalid = 0;
  endtask

  task automatic do_ar(input logic [7:0] len);
    i_arvalid = 1; i_arlen = len; tick(); i_arvalid = 0;
  endtask

  task automatic do_r(input logic last);
    i_rvalid = 1; i_rlast = last; tick(); i_rvalid = 0; i_rlast = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    i_reset = 1;
    tick();
    n_checks++; if (o_status !== 8'h00) begin n_errors++; $display("FAIL reset_status: got %h expected 00", o_status); end
    n_checks++; if (o_asserted !== 1'b0) begin n_errors++; $display("FAIL reset_asserted: got %b expected 0", o_asserted); end
    n_checks++; if (o_wr_bursts !== 16'd0) begin n_errors++; $display("FAIL reset_wr_bursts: got %0d expected 0", o_wr_bursts); end
    n_checks++; if (o_rd_bursts !== 16'd0) begin n_errors++; $display("FAIL reset_rd_bursts: got %0d expected 0", o_rd_bursts); end
    i_reset = 0;
  endtask

  task automatic test_write_burst();
    apply_reset();
    do_aw(8'd3);
    do_w(0); do_w(0); do_w(0); do_w(1);
    n_checks++; if (o_wr_bursts !== 16'd0) begin n_errors++; $display("FAIL wr_before_b: got %0d expected 0", o_wr_bursts); end
    do_b();
    tick();
    n_checks++; if (o_status !== 8'h00) begin n_errors++; $display("FAIL wr_status: got %h expected 00", o_status); end
    n_checks++; if (o_wr_bursts !== 16'd1) begin n_errors++; $display("FAIL wr_bursts: got %0d expected 1", o_wr_bursts); end
    n_checks++; if (o_asserted !== 1'b0) begin n_errors++; $display("FAIL wr_asserted: got %b expected 0", o_asserted); end
    n_checks++; if (o_rd_bursts !== 16'd0) begin n_errors++; $display("FAIL wr_rd_bursts: got %0d expected 0", o_rd_bursts); end
  endtask

  task automatic test_wlast_mismatch();
    apply_reset();
    do_aw(8'd1);
    do_w(1);  // early wlast
    n_checks++; if (o_status !== 8'h20) begin n_errors++; $display("FAIL wlast_status: got %h expected 20", o_status); end
    n_checks++; if (o_asserted !== 1'b0) begin n_errors++; $display("FAIL wlast_asserted_early: got %b expected 0", o_asserted); end
    do_w(0);  // counted last beat, pops the queue
    n_checks++; if (o_asserted !== 1'b1) begin n_errors++; $display("FAIL wlast_asserted: got %b expected 1", o_asserted); end
    do_b();
    do_aw(8'd0);
    do_w(1);
    do_b();
    n_checks++; if (o_wr_bursts !== 16'd2) begin n_errors++; $display("FAIL wlast_pop_wr_bursts: got %0d expected 2", o_wr_bursts); end
    n_checks++; if (o_status !== 8'h20) begin n_errors++; $display("FAIL wlast_pop_status: got %h expected 20", o_status); end
  endtask

  task automatic test_ar_overflow();
    apply_reset();
    for (int i = 0; i < 4; i++) do_ar(8'd0);
    n_checks++; if (o_status !== 8'h00) begin n_errors++; $display("FAIL ar_fill_status: got %h expected 00", o_status); end
    do_ar(8'd0);
    n_checks++; if (o_status !== 8'h80) begin n_errors++; $display("FAIL ar_ovf_status: got %h expected 80", o_status); end
    for (int i = 0; i < 4; i++) do_r(1);
    n_checks++; if (o_rd_bursts !== 16'd4) begin n_errors++; $display("FAIL ar_rd_bursts: got %0d expected 4", o_rd_bursts); end
    n_checks++; if (o_status !== 8'h80) begin n_errors++; $display("FAIL ar_drain_status: got %h expected 80", o_status); end
  endtask

  task automatic test_valid_drop();
    apply_reset();
    i_arvalid = 1; i_arready = 0;
    tick();
    i_arvalid = 0; i_arready = 1;
    tick();
    n_checks++; if (o_status !== 8'h04) begin n_errors++; $display("FAIL drop_status: got %h expected 04", o_status); end
    n_checks++; if (o_asserted !== 1'b0) begin n_errors++; $display("FAIL drop_asserted_early: got %b expected 0", o_asserted); end
    tick();
    n_checks++; if (o_asserted !== 1'b1) begin n_errors++; $display("FAIL drop_asserted: got %b expected 1", o_asserted); end
    do_b();
    n_checks++; if (o_status !== 8'h84) begin n_errors++; $display("FAIL b_nopend_status: got %h expected 84", o_status); end
    n_checks++; if (o_wr_bursts !== 16'd0) begin n_errors++; $display("FAIL b_nopend_wr_bursts: got %0d expected 0", o_wr_bursts); end
  endtask

  task automatic test_full_same_cycle();
    apply_reset();
    for (int i = 0; i < 4; i++) do_aw(8'd0);
    i_awvalid = 1; i_awlen = 8'd0; i_wvalid = 1; i_wlast = 1;
    tick();
    i_awvalid = 0; i_wvalid = 0; i_wlast = 0;
    n_checks++; if (o_status !== 8'h00) begin n_errors++; $display("FAIL full_push_pop_status: got %h expected 00", o_status); end
    do_b();
    for (int i = 0; i < 4; i++) do_w(1);
    n_checks++; if (o_status !== 8'h00) begin n_errors++; $display("FAIL full_drain_status: got %h expected 00", o_status); end
    for (int i = 0; i < 4; i++) do_b();
    n_checks++; if (o_wr_bursts !== 16'd5) begin n_errors++; $display("FAIL full_wr_bursts: got %0d expected 5", o_wr_bursts); end
    do_w(1);
    n_checks++; if (o_status !== 8'h80) begin n_errors++; $display("FAIL full_empty_w_status: got %h expected 80", o_status); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    do_ar(8'd0);
    do_r(0);
    n_checks++; if (o_status !== 8'h40) begin n_errors++; $display("FAIL pre_rst_status: got %h expected 40", o_status); end
    n_checks++; if (o_rd_bursts !== 16'd1) begin n_errors++; $display("FAIL pre_rst_rd_bursts: got %0d expected 1", o_rd_bursts); end
    do_ar(8'd7);
    do_r(0); do_r(0); do_r(0);
    i_rvalid = 1; i_rready = 0;
    tick();
    i_reset = 1; i_rvalid = 0; i_rready = 1;
    #1;
    n_checks++; if (o_status !== 8'h00) begin n_errors++; $display("FAIL midrst_status: got %h expected 00", o_status); end
    n_checks++; if (o_asserted !== 1'b0) begin n_errors++; $display("FAIL midrst_asserted: got %b expected 0", o_asserted); end
    n_checks++; if (o_rd_bursts !== 16'd0) begin n_errors++; $display("FAIL midrst_rd_bursts: got %0d expected 0", o_rd_bursts); end
    n_checks++; if (o_wr_bursts !== 16'd0) begin n_errors++; $display("FAIL midrst_wr_bursts: got %0d expected 0", o_wr_bursts); end
    tick();
    i_reset = 0;
    tick();
    n_checks++; if (o_status !== 8'h00) begin n_errors++; $display("FAIL post_rst_idle_status: got %h expected 00", o_status); end
    do_ar(8'd0);
    do_r(1);
    n_checks++; if (o_rd_bursts !== 16'd1) begin n_errors++; $display("FAIL post_rst_rd_bursts: got %0d expected 1", o_rd_bursts); end
    n_checks++; if (o_status !== 8'h00) begin n_errors++; $display("FAIL post_rst_status: got %h expected 00", o_status); end
    tick();
    n_checks++; if (o_asserted !== 1'b0) begin n_errors++; $display("FAIL post_rst_asserted: got %b expected 0", o_asserted); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    i_reset = 1;
    test_reset();
    test_write_burst();
    test_wlast_mismatch();
    test_ar_overflow();
    test_valid_drop();
    test_full_same_cycle();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_burst_monitor.md
AXI4_BURST_MONITOR -- requirements
Module: axi4_burst_monitor

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4: depth of each outstanding-burst length FIFO (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16: width of the completed-burst counters.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 awvalid/awready  in  1 each  AW handshake; awlen  in  8  AW burst length-1.
REQ-006 wvalid/wready/wlast  in  1 each  W handshake and last-beat flag.
REQ-007 bvalid/bready  in  1 each  B handshake.
REQ-008 arvalid/arready  in  1 each  AR handshake; arlen  in  8  AR burst length-1.
REQ-009 rvalid/rready/rlast  in  1 each  R handshake and last-beat flag.
REQ-010 status  out  8  sticky violation flags, bit map in REQ-020.
REQ-011 asserted  out  1  OR of status, registered.
REQ-012 wr_bursts/rd_bursts  out  CNT_W each  completed write (B accepted) / read (RLAST accepted) bursts.

Function
REQ-013 A handshake on a channel SHALL mean valid&ready sampled high at a rising edge.
REQ-014 Each AW handshake SHALL push awlen into the AW FIFO; each AR handshake SHALL push arlen into the AR FIFO.
REQ-015 The W beat counter SHALL start at 0, increment per W handshake, and compare against the AW FIFO head; the expected last beat is counter==head.
REQ-016 On the expected last W beat: counter clears, AW FIFO pops, pending-B count increments; same cycle AW push and pop SHALL both take effect (occupancy unchanged).
REQ-017 A W handshake with wlast != expected-last SHALL set status[5]; the counter SHALL still follow awlen, not wlast.
REQ-018 R path SHALL mirror REQ-015..017 using AR FIFO, rlast and status[6]; an expected-last R beat SHALL pop the AR FIFO and increment rd_bursts.
REQ-019 B handshake SHALL decrement pending-B and increment wr_bursts; simultaneous increment and decrement SHALL leave pending-B unchanged.
REQ-020 status bits: [0] awvalid fell without handshake; [1] wvalid ditto; [2] arvalid ditto; [3] rvalid ditto; [4] bvalid ditto; [5] WLAST mismatch; [6] RLAST mismatch; [7] protocol-count error (REQ-021).
REQ-021 status[7] SHALL set on: push to a full AW/AR FIFO (push dropped); W beat with AW FIFO empty; R beat with AR FIFO empty; B handshake with pending-B==0 (no decrement); pending-B increment at MAX_OUT.
REQ-022 Valid-drop detection SHALL register previous valid&!ready per channel and flag when valid is low in the following cycle.
REQ-023 Status bits SHALL be sticky until reset; asserted SHALL rise one cycle after the first status bit sets.
REQ-024 wr_bursts and rd_bursts SHALL saturate at all-ones, never wrap.
REQ-025 The monitor SHALL be purely observational: no output feeds back into the bus.

Reset
REQ-026 While reset is high: status=0, asserted=0, wr_bursts=rd_bursts=0, both FIFOs empty, beat counters 0, pending-B 0, valid-history 0.
REQ-027 Reset asserted mid-burst SHALL discard all in-flight state immediately; first cycle after release SHALL be treated as idle, no valid-drop flag from pre-reset history.

Verification
REQ-028 AW awlen=3, four W beats with wlast on 4th, then B -> status=0, wr_bursts=1, asserted=0.
REQ-029 AW awlen=1, W beats with wlast on 1st beat -> status[5]=1 next cycle, asserted=1 cycle after; second beat pops FIFO.
REQ-030 Four AR (arlen=0) pushed with no R, fifth AR -> status[7]=1; four single-beat R with rlast -> rd_bursts=4.
REQ-031 arvalid high with arready low, then arvalid low next cycle -> status[2]=1; bvalid with pending-B=0 handshaked -> status[7]=1, wr_bursts unchanged.
REQ-032 Same-cycle AW push and last W beat with FIFO full (MAX_OUT entries) -> no overflow flag, occupancy stays MAX_OUT.
REQ-033 reset pulsed mid 8-beat read -> all outputs 0; fresh AR arlen=0 plus one R beat -> rd_bursts=1, status=0.
